mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Single-port memory arbiter for the pipe_MIPS32 unified word memory.
- Shares one memory port between three requesters: instruction fetch (IF stage), data load/store (MEM stage), and a program loader that writes memory while the processor is halted.
- Sequences each access through a fixed issue/wait/respond FSM.
- Provides anti-starvation for fetch against back-to-back data traffic.

Parameters:
- AW, 10, word-address width (1024 x 32-bit words).
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles after the mem_en cycle; legal range 1..7.
- STARVE_LIMIT, 4, consecutive lost fetch arbitrations before fetch is promoted over data; legal range 1..15.

Ports:
- clk1  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- halted  in  1  processor HALTED flag; loader requests are honoured only while this is 1.
- if_req  in  1  fetch read request; held until if_ack.
- if_addr  in  AW  fetch word address.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  DW  fetch read data.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data word address.
- dm_wdata  in  DW  store data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  DW  load data; valid with dm_ack when dm_we = 0.
- ld_req  in  1  loader write request; held until ld_ack.
- ld_addr  in  AW  loader word address.
- ld_wdata  in  DW  loader write data.
- ld_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  1 whenever the FSM is not in IDLE.
- grant_id  out  2  current owner: 0 = none, 1 = fetch, 2 = data, 3 = loader.

Behaviour:
- Reset: state IDLE, starvation counter 0.
  - All outputs 0: acks, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, busy, grant_id.
- Requester contract:
  - req, addr, we and wdata stay stable from assertion through the ack cycle.
  - req drops in the cycle after ack, or stays high to start a new request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples requests at the clock edge; if any eligible request exists, latches winner, address, we and wdata, then moves to ISSUE.
  - Priority: loader (only when halted = 1) > data > fetch.
  - Exception: when starve_cnt == STARVE_LIMIT, fetch beats data; loader still beats fetch.
- ISSUE (1 cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata driven from the latched values.
  - Write → RESP. Read → WAIT.
- WAIT (MEM_LAT cycles):
  - Counter runs; mem_rdata is captured into the winner's rdata register at the end of the last WAIT cycle → RESP.
- RESP (1 cycle):
  - Winner's ack = 1 → IDLE.
  - rdata holds its value until the next read by the same requester.
- Latency, request first seen high in IDLE cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 2 + MEM_LAT (cycle 3 at the default).
- Throughput: one access per 3 cycles for writes, 3 + MEM_LAT cycles for reads. Back-to-back requests from one requester are allowed.
- Starvation counter (4-bit, saturating at STARVE_LIMIT):
  - Increments at each IDLE arbitration where if_req = 1 and fetch loses to data.
  - Clears when fetch is granted.
  - Unchanged when fetch loses to the loader.
- Loader gating: ld_req while halted = 0 is ignored, with no ack. halted falling mid-loader-access does not abort the access.
- grant_id = winner from ISSUE through RESP; 0 in IDLE.
- Reset mid-operation: the FSM aborts to IDLE and no ack is issued. Any write already strobed stays performed. Requesters re-issue.
- Simultaneous fetch and data requests at default parameters: data wins 4 times, then fetch wins once.
- mem_addr wraps naturally at AW bits; no range checking.

Decomposition:
- mips_pkg (shared package):
  - grant_id encodings GNT_NONE/GNT_IF/GNT_DM/GNT_LD.
  - FSM state encoding arb_state_t.
  - Default AW and DW constants.
- One sub-module, mips_arb_prio: combinational priority and starvation-promote selector.
  - Inputs: requests, halted, promote.
  - Output: one-hot winner.
  - Keeps the FSM free of priority logic and allows unit testing of the selector alone.

Test Plan:
- Loader write with halted = 1: ld_addr = 120, ld_wdata = 85 → mem_en/mem_we high in cycle 1 with mem_addr = 120; ld_ack in cycle 2; grant_id = 3 during cycles 1–2.
- Fetch read, MEM_LAT = 1, memory model returns 32'h28010078 at address 0 → if_ack in cycle 3 with if_rdata = 32'h28010078; busy high in cycles 1–3.
- Data load from address 120 followed by a data store of 130 to address 121 → dm_rdata = 85 on the first ack; memory word 121 = 130 after the second ack; no fetch activity.
- if_req and dm_req held continuously → grant sequence DM, DM, DM, DM, IF, DM, … with the counter clearing on each IF grant.
- ld_req asserted with halted = 0 for 20 cycles → no ld_ack and no mem_en. Then halted = 1 → ld_ack 2 cycles after the next IDLE.
- reset pulsed during WAIT of a fetch read → no if_ack; all outputs 0 in the following cycle; the re-issued fetch completes normally with correct data.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the pipe_MIPS32 memory arbiter.
// Grant ids, one-hot winner codes and FSM states.
package mips_pkg;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 32;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_IF   = 2'd1;
   localparam logic [1:0] GNT_DM   = 2'd2;
   localparam logic [1:0] GNT_LD   = 2'd3;

   localparam logic [2:0] WIN_NONE = 3'b000;
   localparam logic [2:0] WIN_IF   = 3'b001;
   localparam logic [2:0] WIN_DM   = 3'b010;
   localparam logic [2:0] WIN_LD   = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } arb_state_t;

endpackage

// File: rtl/mips_arb_prio.sv
// Priority selector: loader (halted only) > data > fetch,
// with fetch promoted over data once it has starved.
module mips_arb_prio
   import mips_pkg::*;
(
   input  logic       if_req,
   input  logic       dm_req,
   input  logic       ld_req,
   input  logic       halted,
   input  logic       promote,
   output logic [2:0] win
);

   always_comb begin
      win = WIN_NONE;
      if (ld_req && halted)
         win = WIN_LD;
      else if (if_req && promote)
         win = WIN_IF;
      else if (dm_req)
         win = WIN_DM;
      else if (if_req)
         win = WIN_IF;
   end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port word-memory arbiter for fetch, data and loader.
// Each access runs IDLE -> ISSUE -> (WAIT) -> RESP.
module mips_mem_arbiter
   import mips_pkg::*;
#(
   parameter int AW           = AW_DEF,
   parameter int DW           = DW_DEF,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk1,
   input  logic          reset,
   input  logic          halted,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_ack,
   output logic [DW-1:0] dm_rdata,
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic [1:0]    grant_id
);

   arb_state_t    state;
   arb_state_t    nxt;
   logic [1:0]    gnt;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          we_q;
   logic [2:0]    wcnt;
   logic [3:0]    starve;
   logic [2:0]    win;
   logic          promote;
   logic          last;

   assign promote   = (starve == 4'(STARVE_LIMIT));
   assign last      = (wcnt == 3'(MEM_LAT - 1));
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   mips_arb_prio u_prio (
      .if_req  (if_req),
      .dm_req  (dm_req),
      .ld_req  (ld_req),
      .halted  (halted),
      .promote (promote),
      .win     (win)
   );

   always_ff @(posedge clk1) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt      = state;
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      busy     = 1'b1;
      grant_id = gnt;
      if_ack   = 1'b0;
      dm_ack   = 1'b0;
      ld_ack   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            busy     = 1'b0;
            grant_id = GNT_NONE;
            if (win != WIN_NONE)
               nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            mem_en = 1'b1;
            mem_we = we_q;
            nxt    = we_q ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            if (last)
               nxt = ST_RESP;
         end
         ST_RESP: begin
            if_ack = (gnt == GNT_IF);
            dm_ack = (gnt == GNT_DM);
            ld_ack = (gnt == GNT_LD);
            nxt    = ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         gnt      <= GNT_NONE;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         wcnt     <= '0;
         starve   <= '0;
         if_rdata <= '0;
         dm_rdata <= '0;
      end else begin
         if (state == ST_IDLE) begin
            unique case (1'b1)
               win[2]: begin
                  gnt     <= GNT_LD;
                  addr_q  <= ld_addr;
                  wdata_q <= ld_wdata;
                  we_q    <= 1'b1;
               end
               win[1]: begin
                  gnt     <= GNT_DM;
                  addr_q  <= dm_addr;
                  wdata_q <= dm_wdata;
                  we_q    <= dm_we;
               end
               win[0]: begin
                  gnt    <= GNT_IF;
                  addr_q <= if_addr;
                  we_q   <= 1'b0;
               end
               default: ;
            endcase
            // only a loss to data counts as starvation
            if (win[0])
               starve <= '0;
            else if (win[1] && if_req && !promote)
               starve <= starve + 4'd1;
         end
         if (state == ST_ISSUE)
            wcnt <= '0;
         else if (state == ST_WAIT)
            wcnt <= wcnt + 3'd1;
         if (state == ST_WAIT && last) begin
            if (gnt == GNT_IF)
               if_rdata <= mem_rdata;
            else if (gnt == GNT_DM)
               dm_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios
// plus randomized traffic against a transaction-level model.
module tb_mips_mem_arbiter;
   import mips_pkg::*;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk1 = 1'b0;
   logic          reset = 1'b1;
   logic          halted = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic          dm_ack;
   logic [DW-1:0] dm_rdata;
   logic          ld_req = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_wdata = '0;
   logic          ld_ack;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy;
   logic [1:0]    grant_id;

   logic [DW-1:0] mem [0:1023];
   logic [DW-1:0] ref_mem [0:1023];
   int checks = 0;
   int errors = 0;

   mips_mem_arbiter dut (
      .clk1      (clk1),
      .reset     (reset),
      .halted    (halted),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_ack    (dm_ack),
      .dm_rdata  (dm_rdata),
      .ld_req    (ld_req),
      .ld_addr   (ld_addr),
      .ld_wdata  (ld_wdata),
      .ld_ack    (ld_ack),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 clk1 = ~clk1;

   // memory with one cycle of read latency
   always @(posedge clk1) begin
      if (mem_en) begin
         if (mem_we)
            mem[mem_addr] = mem_wdata;
         else
            mem_rdata <= mem[mem_addr];
      end
   end

   task automatic cyc;
      @(posedge clk1);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) cyc();
      checks++;
      if ({if_ack, dm_ack, ld_ack, mem_en, mem_we, busy, grant_id,
           mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0)
         begin
            errors++;
            $display("FAIL reset_outputs got busy=%b gnt=%0d en=%b addr=%0d exp all 0",
                     busy, grant_id, mem_en, mem_addr);
         end
      reset = 1'b0;
   endtask

   task automatic test_loader_write;
      halted   = 1'b1;
      ld_req   = 1'b1;
      ld_addr  = 10'd120;
      ld_wdata = 32'd85;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ld_c0_busy got %b exp 0", busy);
      end
      cyc();
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, grant_id, ld_ack} !==
          {1'b1, 1'b1, 10'd120, 32'd85, 2'd3, 1'b0}) begin
         errors++;
         $display("FAIL ld_c1_issue got en=%b we=%b a=%0d d=%0d g=%0d ack=%b exp 1 1 120 85 3 0",
                  mem_en, mem_we, mem_addr, mem_wdata, grant_id, ld_ack);
      end
      cyc();
      checks++;
      if ({ld_ack, grant_id, mem_en} !== {1'b1, 2'd3, 1'b0}) begin
         errors++;
         $display("FAIL ld_c2_ack got ack=%b g=%0d en=%b exp 1 3 0",
                  ld_ack, grant_id, mem_en);
      end
      cyc();
      ld_req = 1'b0;
      checks++;
      if (busy !== 1'b0 || mem[120] !== 32'd85) begin
         errors++;
         $display("FAIL ld_done got busy=%b mem120=%0d exp 0 85", busy, mem[120]);
      end
   endtask

   task automatic test_fetch_read;
      mem[0]  = 32'h28010078;
      if_req  = 1'b1;
      if_addr = '0;
      cyc();
      checks++;
      if ({busy, grant_id, mem_en, mem_we} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL if_c1 got busy=%b g=%0d en=%b we=%b exp 1 1 1 0",
                  busy, grant_id, mem_en, mem_we);
      end
      cyc();
      checks++;
      if ({busy, if_ack} !== 2'b10) begin
         errors++;
         $display("FAIL if_c2 got busy=%b ack=%b exp 1 0", busy, if_ack);
      end
      cyc();
      checks++;
      if ({busy, if_ack} !== 2'b11 || if_rdata !== 32'h28010078) begin
         errors++;
         $display("FAIL if_c3 got busy=%b ack=%b data=%h exp 1 1 28010078",
                  busy, if_ack, if_rdata);
      end
      cyc();
      if_req = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL if_c4_idle got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_data_ls;
      bit got;
      bit fseen;
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 10'd120;
      repeat (3) cyc();
      checks++;
      if (dm_ack !== 1'b1 || dm_rdata !== 32'd85) begin
         errors++;
         $display("FAIL dm_load got ack=%b data=%0d exp 1 85", dm_ack, dm_rdata);
      end
      cyc();
      dm_we    = 1'b1;
      dm_addr  = 10'd121;
      dm_wdata = 32'd130;
      got   = 1'b0;
      fseen = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         cyc();
         if (if_ack || grant_id == GNT_IF) fseen = 1'b1;
         if (dm_ack) got = 1'b1;
      end
      checks++;
      if (!got || mem[121] !== 32'd130 || fseen) begin
         errors++;
         $display("FAIL dm_store got ack=%b mem121=%0d fetch=%b exp 1 130 0",
                  got, mem[121], fseen);
      end
      cyc();
      dm_req = 1'b0;
      dm_we  = 1'b0;
   endtask

   task automatic test_starve;
      int k;
      bit exp_if;
      if_addr = 10'd1;
      dm_addr = 10'd2;
      dm_we   = 1'b0;
      if_req  = 1'b1;
      dm_req  = 1'b1;
      k = 0;
      for (int i = 0; i < 200 && k < 15; i++) begin
         cyc();
         if (if_ack || dm_ack) begin
            exp_if = (k % 5 == 4);
            checks++;
            if (if_ack !== exp_if || dm_ack !== !exp_if) begin
               errors++;
               $display("FAIL starve_grant%0d got if=%b dm=%b exp if=%b",
                        k, if_ack, dm_ack, exp_if);
            end
            k++;
         end
      end
      if (k < 15) begin
         checks++;
         errors++;
         $display("FAIL starve_timeout got %0d acks exp 15", k);
      end
      cyc();
      if_req = 1'b0;
      dm_req = 1'b0;
   endtask

   task automatic test_loader_gate;
      bit bad;
      logic [DW-1:0] v;
      v        = $urandom;
      halted   = 1'b0;
      ld_req   = 1'b1;
      ld_addr  = 10'd200;
      ld_wdata = v;
      bad = 1'b0;
      repeat (20) begin
         cyc();
         if (ld_ack || mem_en || busy) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL ld_gated got activity=%b exp 0", bad);
      end
      halted = 1'b1;
      cyc();
      checks++;
      if (ld_ack !== 1'b0) begin
         errors++;
         $display("FAIL ld_gate_c1 got ack=%b exp 0", ld_ack);
      end
      cyc();
      checks++;
      if (ld_ack !== 1'b1) begin
         errors++;
         $display("FAIL ld_gate_c2 got ack=%b exp 1", ld_ack);
      end
      cyc();
      ld_req = 1'b0;
      checks++;
      if (mem[200] !== v) begin
         errors++;
         $display("FAIL ld_gate_mem got %h exp %h", mem[200], v);
      end
   endtask

   task automatic test_reset_mid;
      logic [DW-1:0] v;
      bit early;
      v       = $urandom;
      mem[5]  = v;
      if_req  = 1'b1;
      if_addr = 10'd5;
      cyc();
      cyc();
      checks++;
      if ({busy, if_ack, mem_en} !== 3'b100) begin
         errors++;
         $display("FAIL rst_mid_wait got busy=%b ack=%b en=%b exp 1 0 0",
                  busy, if_ack, mem_en);
      end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      checks++;
      if ({if_ack, dm_ack, ld_ack, mem_en, mem_we, busy, grant_id,
           mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
         errors++;
         $display("FAIL rst_mid_clear got busy=%b ack=%b g=%0d rd=%h exp all 0",
                  busy, if_ack, grant_id, if_rdata);
      end
      early = 1'b0;
      repeat (2) begin
         cyc();
         if (if_ack) early = 1'b1;
      end
      cyc();
      checks++;
      if (early || if_ack !== 1'b1 || if_rdata !== v) begin
         errors++;
         $display("FAIL rst_mid_reissue got early=%b ack=%b rd=%h exp 0 1 %h",
                  early, if_ack, if_rdata, v);
      end
      cyc();
      if_req = 1'b0;
   endtask

   task automatic test_random;
      bit            pend [3];
      int            owner;
      int            exp_ack;
      bit            exp_wr;
      logic [DW-1:0] exp_rd;
      int            sc;
      int            w;
      logic [2:0]    exp_vec;
      logic [DW-1:0] got_rd;
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      pend[0] = 0;
      pend[1] = 0;
      pend[2] = 0;
      owner   = -1;
      exp_ack = 0;
      exp_wr  = 0;
      exp_rd  = '0;
      sc      = 0;
      halted  = 1'b1;
      if_req  = 1'b0;
      dm_req  = 1'b0;
      ld_req  = 1'b0;
      reset   = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
      for (int t = 0; t < 600; t++) begin
         if (owner >= 0 && exp_ack == t - 1) begin
            pend[owner] = 0;
            owner = -1;
         end
         if (!pend[0] && $urandom_range(0, 1) == 1) begin
            pend[0] = 1;
            if_addr = 10'($urandom_range(0, 31));
         end
         if (!pend[1] && $urandom_range(0, 1) == 1) begin
            pend[1]  = 1;
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = 10'($urandom_range(0, 31));
            dm_wdata = $urandom;
         end
         if (!pend[2] && $urandom_range(0, 3) == 0) begin
            pend[2]  = 1;
            ld_addr  = 10'($urandom_range(0, 31));
            ld_wdata = $urandom;
         end
         if ($urandom_range(0, 15) == 0) halted = ~halted;
         if_req = pend[0];
         dm_req = pend[1];
         ld_req = pend[2];
         if (owner < 0) begin
            w = -1;
            if (pend[2] && halted)
               w = 2;
            else if (pend[1] && !(pend[0] && sc == 4))
               w = 1;
            else if (pend[0])
               w = 0;
            if (w == 0)
               sc = 0;
            else if (w == 1 && pend[0] && sc < 4)
               sc++;
            if (w >= 0) begin
               owner = w;
               exp_wr = (w == 2) || (w == 1 && dm_we);
               if (w == 2)
                  ref_mem[ld_addr] = ld_wdata;
               else if (w == 1 && dm_we)
                  ref_mem[dm_addr] = dm_wdata;
               else if (w == 1)
                  exp_rd = ref_mem[dm_addr];
               else
                  exp_rd = ref_mem[if_addr];
               exp_ack = t + (exp_wr ? 2 : 3);
            end
         end
         exp_vec = (owner >= 0 && exp_ack == t) ? (3'b001 << owner) : 3'b000;
         checks++;
         if ({ld_ack, dm_ack, if_ack} !== exp_vec) begin
            errors++;
            $display("FAIL rand_ack t=%0d got %b exp %b", t,
                     {ld_ack, dm_ack, if_ack}, exp_vec);
         end
         if (exp_vec != 3'b000 && !exp_wr) begin
            got_rd = (owner == 0) ? if_rdata : dm_rdata;
            checks++;
            if (got_rd !== exp_rd) begin
               errors++;
               $display("FAIL rand_rdata t=%0d who=%0d got %h exp %h",
                        t, owner, got_rd, exp_rd);
            end
         end
         cyc();
      end
      reset  = 1'b1;
      if_req = 1'b0;
      dm_req = 1'b0;
      ld_req = 1'b0;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_loader_write();
      test_fetch_read();
      test_data_ls();
      test_starve();
      test_loader_gate();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
